// File: rtl/ysyx_24080006_idu.sv
// ============================================================================
// ysyx_24080006_idu : instruction decode stage (accept, decode, hold to EXU)
// Revision 1.0
// ============================================================================
`default_nettype none

module ysyx_24080006_idu #(
  parameter int RF_AW = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ifu2idu_valid,
  input  logic [31:0]      ifu2idu_inst,
  input  logic [31:0]      ifu2idu_pc,
  output logic             idu2ifu_ready,
  output logic [RF_AW-1:0] rf_raddr1,
  output logic [RF_AW-1:0] rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  input  logic             exu2idu_ready,
  output logic             idu2exu_valid,
  output logic [31:0]      pc,
  output logic [31:0]      inst,
  output logic [31:0]      src1,
  output logic [31:0]      src2,
  output logic [31:0]      imm,
  output logic [RF_AW-1:0] rd,
  output logic [3:0]       alu_op,
  output logic             a_pc,
  output logic             b_imm,
  output logic             rf_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             branch,
  output logic             jump,
  output logic             csr,
  output logic             ecall,
  output logic             ebreak,
  output logic             mret,
  output logic             illegal,
  output logic [2:0]       funct3
);

  localparam logic [6:0] c_lui    = 7'b0110111;
  localparam logic [6:0] c_auipc  = 7'b0010111;
  localparam logic [6:0] c_jal    = 7'b1101111;
  localparam logic [6:0] c_jalr   = 7'b1100111;
  localparam logic [6:0] c_branch = 7'b1100011;
  localparam logic [6:0] c_load   = 7'b0000011;
  localparam logic [6:0] c_store  = 7'b0100011;
  localparam logic [6:0] c_opimm  = 7'b0010011;
  localparam logic [6:0] c_op     = 7'b0110011;
  localparam logic [6:0] c_fence  = 7'b0001111;
  localparam logic [6:0] c_system = 7'b1110011;

  localparam logic [3:0] c_alu_add = 4'd0;

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;
  state_t state;

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? 4'd1 : 4'd0;
      3'b001:  alu_of = 4'd2;
      3'b010:  alu_of = 4'd3;
      3'b011:  alu_of = 4'd4;
      3'b100:  alu_of = 4'd5;
      3'b101:  alu_of = alt ? 4'd7 : 4'd6;
      3'b110:  alu_of = 4'd8;
      default: alu_of = 4'd9;
    endcase
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  logic [3:0]  w_alu;
  logic        w_a_pc, w_b_imm, w_we, w_mrd, w_mwr, w_br, w_jmp, w_csr;
  logic        w_ecall, w_ebreak, w_mret, w_bad, w_zero_src1;
  logic        w_use_rd, w_use_rs1, w_use_rs2;
  logic        w_idx_bad, w_illegal, w_rd_nz;

  assign w_opcode = ifu2idu_inst[6:0];
  assign w_f3     = ifu2idu_inst[14:12];
  assign w_f7     = ifu2idu_inst[31:25];
  assign w_imm_i  = {{20{ifu2idu_inst[31]}}, ifu2idu_inst[31:20]};
  assign w_imm_s  = {{20{ifu2idu_inst[31]}}, ifu2idu_inst[31:25], ifu2idu_inst[11:7]};
  assign w_imm_b  = {{20{ifu2idu_inst[31]}}, ifu2idu_inst[7], ifu2idu_inst[30:25],
                     ifu2idu_inst[11:8], 1'b0};
  assign w_imm_u  = {ifu2idu_inst[31:12], 12'b0};
  assign w_imm_j  = {{12{ifu2idu_inst[31]}}, ifu2idu_inst[19:12], ifu2idu_inst[20],
                     ifu2idu_inst[30:21], 1'b0};

  assign rf_raddr1     = ifu2idu_inst[15 +: RF_AW];
  assign rf_raddr2     = ifu2idu_inst[20 +: RF_AW];
  assign idu2ifu_ready = (state == IDLE);
  assign idu2exu_valid = (state == HOLD);

  always_comb begin
    w_imm       = '0;
    w_alu       = c_alu_add;
    w_a_pc      = 1'b0;
    w_b_imm     = 1'b0;
    w_we        = 1'b0;
    w_mrd       = 1'b0;
    w_mwr       = 1'b0;
    w_br        = 1'b0;
    w_jmp       = 1'b0;
    w_csr       = 1'b0;
    w_ecall     = 1'b0;
    w_ebreak    = 1'b0;
    w_mret      = 1'b0;
    w_bad       = 1'b0;
    w_zero_src1 = 1'b0;
    w_use_rd    = 1'b0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    case (w_opcode)
      c_lui: begin
        w_imm = w_imm_u; w_b_imm = 1'b1; w_we = 1'b1; w_zero_src1 = 1'b1; w_use_rd = 1'b1;
      end
      c_auipc: begin
        w_imm = w_imm_u; w_a_pc = 1'b1; w_b_imm = 1'b1; w_we = 1'b1; w_use_rd = 1'b1;
      end
      c_jal: begin
        w_imm = w_imm_j; w_jmp = 1'b1; w_a_pc = 1'b1; w_b_imm = 1'b1; w_we = 1'b1;
        w_use_rd = 1'b1;
      end
      c_jalr: begin
        w_imm = w_imm_i; w_jmp = 1'b1; w_b_imm = 1'b1; w_we = 1'b1;
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_bad = (w_f3 != 3'b000);
      end
      c_branch: begin
        w_imm = w_imm_b; w_br = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      c_load: begin
        w_imm = w_imm_i; w_mrd = 1'b1; w_b_imm = 1'b1; w_we = 1'b1;
        w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      c_store: begin
        w_imm = w_imm_s; w_mwr = 1'b1; w_b_imm = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_bad = (w_f3[2] == 1'b1) || (w_f3 == 3'b011);
      end
      c_opimm: begin
        w_imm = w_imm_i; w_b_imm = 1'b1; w_we = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        w_alu = alu_of(w_f3, (w_f3 == 3'b101) && w_f7[5]);
        if (w_f3 == 3'b001)
          w_bad = (w_f7 != 7'b0000000);
        else if (w_f3 == 3'b101)
          w_bad = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
      end
      c_op: begin
        w_we = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_alu = alu_of(w_f3, w_f7[5]);
        w_bad = ((w_f7 != 7'b0000000) && (w_f7 != 7'b0100000)) ||
                (w_f7[5] && (w_f3 != 3'b000) && (w_f3 != 3'b101));
      end
      c_fence: ;
      c_system: begin
        w_imm = w_imm_i;
        if (w_f3 == 3'b000) begin
          w_ecall  = (ifu2idu_inst == 32'h0000_0073);
          w_ebreak = (ifu2idu_inst == 32'h0010_0073);
          w_mret   = (ifu2idu_inst == 32'h3020_0073);
          w_bad    = !(w_ecall || w_ebreak || w_mret);
        end else begin
          w_csr = 1'b1; w_we = 1'b1; w_use_rd = 1'b1; w_use_rs1 = !w_f3[2];
          w_bad = (w_f3 == 3'b100);
        end
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Narrow register files flag any referenced index with its top bit set
  assign w_idx_bad = (RF_AW < 5) && ((w_use_rd  && ifu2idu_inst[11]) ||
                                     (w_use_rs1 && ifu2idu_inst[19]) ||
                                     (w_use_rs2 && ifu2idu_inst[24]));
  assign w_illegal = w_bad || (ifu2idu_inst[1:0] != 2'b11) || w_idx_bad;
  assign w_rd_nz   = (ifu2idu_inst[11:7] != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      inst    <= '0;
      src1    <= '0;
      src2    <= '0;
      imm     <= '0;
      rd      <= '0;
      alu_op  <= '0;
      a_pc    <= 1'b0;
      b_imm   <= 1'b0;
      rf_we   <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      branch  <= 1'b0;
      jump    <= 1'b0;
      csr     <= 1'b0;
      ecall   <= 1'b0;
      ebreak  <= 1'b0;
      mret    <= 1'b0;
      illegal <= 1'b0;
      funct3  <= '0;
    end else begin
      case (state)
        IDLE: if (ifu2idu_valid) begin
          state   <= HOLD;
          pc      <= ifu2idu_pc;
          inst    <= ifu2idu_inst;
          src1    <= w_zero_src1 ? 32'd0 : rf_rdata1;
          src2    <= rf_rdata2;
          imm     <= w_imm;
          rd      <= ifu2idu_inst[7 +: RF_AW];
          alu_op  <= w_alu;
          a_pc    <= w_a_pc;
          b_imm   <= w_b_imm;
          rf_we   <= w_we && w_rd_nz && !w_illegal;
          mem_rd  <= w_mrd && !w_illegal;
          mem_wr  <= w_mwr && !w_illegal;
          branch  <= w_br && !w_illegal;
          jump    <= w_jmp && !w_illegal;
          csr     <= w_csr && !w_illegal;
          ecall   <= w_ecall;
          ebreak  <= w_ebreak;
          mret    <= w_mret;
          illegal <= w_illegal;
          funct3  <= w_f3;
        end
        HOLD: if (exu2idu_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24080006_idu.sv
// ============================================================================
// tb_ysyx_24080006_idu : directed vector bench for the decode stage
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_24080006_idu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu2idu_valid = 1'b0;
  logic [31:0] ifu2idu_inst = '0;
  logic [31:0] ifu2idu_pc = '0;
  logic        idu2ifu_ready;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1 = '0;
  logic [31:0] rf_rdata2 = '0;
  logic        exu2idu_ready = 1'b0;
  logic        idu2exu_valid;
  logic [31:0] pc, inst, src1, src2, imm;
  logic [4:0]  rd;
  logic [3:0]  alu_op;
  logic        a_pc, b_imm, rf_we, mem_rd, mem_wr, branch, jump, csr;
  logic        ecall, ebreak, mret, illegal;
  logic [2:0]  funct3;

  int checks = 0;
  int errors = 0;

  ysyx_24080006_idu #(.RF_AW(5)) dut (
    .clock(clock), .reset(reset),
    .ifu2idu_valid(ifu2idu_valid), .ifu2idu_inst(ifu2idu_inst), .ifu2idu_pc(ifu2idu_pc),
    .idu2ifu_ready(idu2ifu_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .exu2idu_ready(exu2idu_ready), .idu2exu_valid(idu2exu_valid),
    .pc(pc), .inst(inst), .src1(src1), .src2(src2), .imm(imm), .rd(rd),
    .alu_op(alu_op), .a_pc(a_pc), .b_imm(b_imm), .rf_we(rf_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .jump(jump), .csr(csr),
    .ecall(ecall), .ebreak(ebreak), .mret(mret), .illegal(illegal), .funct3(funct3)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  localparam logic [11:0] K_WE = 12'h800, K_MRD = 12'h400, K_MWR = 12'h200, K_BR = 12'h100;
  localparam logic [11:0] K_J = 12'h080, K_CSR = 12'h040, K_ECL = 12'h020, K_EBK = 12'h010;
  localparam logic [11:0] K_MRT = 12'h008, K_ILL = 12'h004, K_APC = 12'h002, K_BIM = 12'h001;

  typedef struct {
    logic [31:0] inst, pc, rd1, rd2;
    logic [31:0] imm, src1;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [11:0] ctrl;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [31:0] i, p, r1, r2, im, s1,
                              input logic [4:0] d, input logic [3:0] a,
                              input logic [2:0] f, input logic [11:0] c);
    vec_t v;
    v.inst = i; v.pc = p; v.rd1 = r1; v.rd2 = r2; v.imm = im; v.src1 = s1;
    v.rd = d; v.alu = a; v.f3 = f; v.ctrl = c;
    return v;
  endfunction

  function automatic logic [11:0] ctrl_now();
    return {rf_we, mem_rd, mem_wr, branch, jump, csr, ecall, ebreak, mret, illegal, a_pc, b_imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at negedge, accept on the next posedge, sample bundle at the following negedge
  task automatic accept(input logic [31:0] i, p, r1, r2);
    ifu2idu_valid = 1'b1; ifu2idu_inst = i; ifu2idu_pc = p;
    rf_rdata1 = r1; rf_rdata2 = r2;
    @(posedge clock);
    @(negedge clock);
    ifu2idu_valid = 1'b0;
  endtask

  task automatic handoff(input string tag);
    exu2idu_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    exu2idu_ready = 1'b0;
    chk($sformatf("%s.valid_drop", tag), {31'd0, idu2exu_valid}, 32'd0);
    chk($sformatf("%s.ready_back", tag), {31'd0, idu2ifu_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [31:0] w;
    w = v.inst;
    @(negedge clock);
    ifu2idu_inst = v.inst;
    #1;
    chk($sformatf("v%0d.raddr1", n), {27'd0, rf_raddr1}, {27'd0, w[19:15]});
    chk($sformatf("v%0d.raddr2", n), {27'd0, rf_raddr2}, {27'd0, w[24:20]});
    @(negedge clock);
    accept(v.inst, v.pc, v.rd1, v.rd2);
    chk($sformatf("v%0d.valid", n), {31'd0, idu2exu_valid}, 32'd1);
    chk($sformatf("v%0d.inst", n), inst, v.inst);
    chk($sformatf("v%0d.pc", n), pc, v.pc);
    chk($sformatf("v%0d.imm", n), imm, v.imm);
    chk($sformatf("v%0d.src1", n), src1, v.src1);
    chk($sformatf("v%0d.src2", n), src2, v.rd2);
    chk($sformatf("v%0d.rd", n), {27'd0, rd}, {27'd0, v.rd});
    chk($sformatf("v%0d.alu_op", n), {28'd0, alu_op}, {28'd0, v.alu});
    chk($sformatf("v%0d.funct3", n), {29'd0, funct3}, {29'd0, v.f3});
    chk($sformatf("v%0d.ctrl", n), {20'd0, ctrl_now()}, {20'd0, v.ctrl});
    handoff($sformatf("v%0d", n));
  endtask

  initial begin
    vecs[0]  = mk(32'h00500093, 32'h80000000, 32'h11, 32'h22, 32'h5, 32'h11, 5'd1, 4'd0, 3'd0, K_WE | K_BIM);
    vecs[1]  = mk(32'hFFDFF0EF, 32'h30000004, 32'h11, 32'h22, 32'hFFFFFFFC, 32'h11, 5'd1, 4'd0, 3'd7,
                  K_WE | K_J | K_APC | K_BIM);
    vecs[2]  = mk(32'h0020A423, 32'h100, 32'h1000, 32'hDEAD, 32'h8, 32'h1000, 5'd8, 4'd0, 3'd2, K_MWR | K_BIM);
    vecs[3]  = mk(32'h00000000, 32'h104, 32'h11, 32'h22, 32'h0, 32'h11, 5'd0, 4'd0, 3'd0, K_ILL);
    vecs[4]  = mk(32'h00100073, 32'h108, 32'h11, 32'h22, 32'h1, 32'h11, 5'd0, 4'd0, 3'd0, K_EBK);
    vecs[5]  = mk(32'h402081B3, 32'h10C, 32'h33, 32'h44, 32'h0, 32'h33, 5'd3, 4'd1, 3'd0, K_WE);
    vecs[6]  = mk(32'h40335293, 32'h110, 32'h55, 32'h66, 32'h403, 32'h55, 5'd5, 4'd7, 3'd5, K_WE | K_BIM);
    vecs[7]  = mk(32'h40309293, 32'h114, 32'h11, 32'h22, 32'h403, 32'h11, 5'd5, 4'd2, 3'd1, K_ILL | K_BIM);
    vecs[8]  = mk(32'h123453B7, 32'h118, 32'h77, 32'h88, 32'h12345000, 32'h0, 5'd7, 4'd0, 3'd5, K_WE | K_BIM);
    vecs[9]  = mk(32'h00208863, 32'h11C, 32'h11, 32'h22, 32'h10, 32'h11, 5'd16, 4'd0, 3'd0, K_BR);
    vecs[10] = mk(32'h0000B183, 32'h120, 32'h11, 32'h22, 32'h0, 32'h11, 5'd3, 4'd0, 3'd3, K_ILL | K_BIM);
    vecs[11] = mk(32'h300110F3, 32'h124, 32'h11, 32'h22, 32'h300, 32'h11, 5'd1, 4'd0, 3'd1, K_CSR | K_WE);
    vecs[12] = mk(32'h30200073, 32'h128, 32'h11, 32'h22, 32'h302, 32'h11, 5'd0, 4'd0, 3'd0, K_MRT);
    vecs[13] = mk(32'h00500091, 32'h12C, 32'h11, 32'h22, 32'h0, 32'h11, 5'd1, 4'd0, 3'd0, K_ILL);
    vecs[14] = mk(32'h00001117, 32'h130, 32'h11, 32'h22, 32'h1000, 32'h11, 5'd2, 4'd0, 3'd1,
                  K_WE | K_APC | K_BIM);
    vecs[15] = mk(32'h00000073, 32'h134, 32'h11, 32'h22, 32'h0, 32'h11, 5'd0, 4'd0, 3'd0, K_ECL);

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst.valid", {31'd0, idu2exu_valid}, 32'd0);
    chk("rst.ready", {31'd0, idu2ifu_ready}, 32'd1);
    chk("rst.ctrl", {20'd0, ctrl_now()}, 32'd0);
    chk("rst.imm", imm, 32'd0);
    chk("rst.pc", pc, 32'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Stall: EXU not ready for 3 cycles while IFU keeps offering a new instruction
    @(negedge clock);
    accept(32'h00208033, 32'h200, 32'h5, 32'h6);
    ifu2idu_valid = 1'b1; ifu2idu_inst = 32'h00500093; ifu2idu_pc = 32'h204;
    rf_rdata1 = 32'hBAD;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d.valid", c), {31'd0, idu2exu_valid}, 32'd1);
      chk($sformatf("stall%0d.ready", c), {31'd0, idu2ifu_ready}, 32'd0);
      chk($sformatf("stall%0d.inst", c), inst, 32'h00208033);
      chk($sformatf("stall%0d.src1", c), src1, 32'h5);
      chk($sformatf("stall%0d.ctrl", c), {20'd0, ctrl_now()}, 32'd0);
      @(negedge clock);
    end
    handoff("stall");
    @(posedge clock);
    @(negedge clock);
    ifu2idu_valid = 1'b0;
    chk("stall.next_valid", {31'd0, idu2exu_valid}, 32'd1);
    chk("stall.next_inst", inst, 32'h00500093);
    chk("stall.next_pc", pc, 32'h204);
    chk("stall.next_src1", src1, 32'hBAD);
    handoff("stall.next");

    // Reset while holding discards the bundle
    @(negedge clock);
    accept(32'hFFDFF0EF, 32'h30000004, 32'h1, 32'h2);
    chk("rsth.valid_pre", {31'd0, idu2exu_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rsth.valid", {31'd0, idu2exu_valid}, 32'd0);
    chk("rsth.ready", {31'd0, idu2ifu_ready}, 32'd1);
    chk("rsth.imm", imm, 32'd0);
    chk("rsth.ctrl", {20'd0, ctrl_now()}, 32'd0);
    run_vec(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
